alu_seq: RTL and testbench

Registered, parametrised successor to the single-cycle datapath ALU. Keeps the existing 3-bit operation encoding, adds OR and an optional iterative multiply, and produces a full flag set (zero, carry, negative, overflow). Operations enter through a valid/ready handshake and leave as a registered result with a one-cycle done pulse. The block sits between the register-file read ports and the write-back mux of the CPU datapath.

---
 rtl/alu_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready request side, one-cycle done pulse
// and zero/carry/negative/overflow flags.
// Optional iterative shift-and-add multiply (opcode 111) is enabled by
// defining ALU_MUL_EN. Without it, opcode 111 behaves as nop.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_operation,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             neg_flag,
  output logic             ovf_flag
);

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Accepted single-cycle operation waiting for its execute edge
  logic             stg_vld_q, stg_vld_d;
  logic [2:0]       stg_op_q,  stg_op_d;
  logic [WIDTH-1:0] stg_a_q,   stg_a_d;
  logic [WIDTH-1:0] stg_b_q,   stg_b_d;

  // Architectural outputs
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic             accept;

  // Single-cycle execute results
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH-1:0] exe_res;
  logic             exe_carry;
  logic             exe_ovf;
  logic             exe_hold;

`ifdef ALU_MUL_EN
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_step;

  // Ready in IDLE and during the final multiply step, so the next request
  // lands on the completion edge
  assign in_ready = (state_q == ST_IDLE) || (cnt_q == CNT_W'(1));
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
`else
  assign in_ready = 1'b1;
`endif

  assign accept = in_valid && in_ready;

  // Single-cycle datapath operating on the staged operands
  always_comb begin
    sum_ext   = {1'b0, stg_a_q} + {1'b0, stg_b_q};
    dif_ext   = {1'b0, stg_a_q} - {1'b0, stg_b_q};
    exe_res   = stg_a_q;
    exe_carry = 1'b0;
    exe_ovf   = 1'b0;
    exe_hold  = 1'b0;
    case (stg_op_q)
      OP_MOV: exe_res = stg_b_q;
      OP_ADD: begin
        exe_res   = sum_ext[WIDTH-1:0];
        exe_carry = sum_ext[WIDTH];
        exe_ovf   = (stg_a_q[WIDTH-1] == stg_b_q[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != stg_a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exe_res   = dif_ext[WIDTH-1:0];
        exe_carry = dif_ext[WIDTH];
        exe_ovf   = (stg_a_q[WIDTH-1] != stg_b_q[WIDTH-1]) &&
                    (dif_ext[WIDTH-1] != stg_a_q[WIDTH-1]);
      end
      OP_AND: exe_res = stg_a_q & stg_b_q;
      OP_OR:  exe_res = stg_a_q | stg_b_q;
      OP_NOT: exe_res = ~stg_b_q;
      OP_NOP, OP_MUL: begin
        exe_res  = stg_a_q;
        exe_hold = 1'b1;
      end
      default: exe_hold = 1'b1;
    endcase
  end

  // Next-state: staging, completion, and multiply sequencing
  always_comb begin
    stg_vld_d = accept;
    stg_op_d  = accept ? alu_operation : stg_op_q;
    stg_a_d   = accept ? in1 : stg_a_q;
    stg_b_d   = accept ? in2 : stg_b_q;
    result_d  = result_q;
    done_d    = 1'b0;
    zero_d    = zero_q;
    carry_d   = carry_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;

    if (stg_vld_q) begin
      result_d = exe_res;
      done_d   = 1'b1;
      if (!exe_hold) begin
        zero_d  = (exe_res == '0);
        carry_d = exe_carry;
        neg_d   = exe_res[WIDTH-1];
        ovf_d   = exe_ovf;
      end
    end

`ifdef ALU_MUL_EN
    stg_vld_d = accept && (alu_operation != OP_MUL);
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: ;
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = acc_step[WIDTH-1:0];
          done_d   = 1'b1;
          zero_d   = (acc_step[WIDTH-1:0] == '0);
          carry_d  = |acc_step[PW-1:WIDTH];
          neg_d    = acc_step[WIDTH-1];
          ovf_d    = |acc_step[PW-1:WIDTH];
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept && (alu_operation == OP_MUL)) begin
      mcand_d  = PW'(in1);
      mplier_d = in2;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH);
      state_d  = ST_MUL;
    end
`endif
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld_q <= 1'b0;
      stg_op_q  <= OP_NOP;
      stg_a_q   <= '0;
      stg_b_q   <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef ALU_MUL_EN
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      stg_vld_q <= stg_vld_d;
      stg_op_q  <= stg_op_d;
      stg_a_q   <= stg_a_d;
      stg_b_q   <= stg_b_d;
      result_q  <= result_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
`ifdef ALU_MUL_EN
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign result     = result_q;
  assign done       = done_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign neg_flag   = neg_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed and randomized operations checked
// against an arithmetic reference model. Honors ALU_MUL_EN like the design.
module tb_alu_seq;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   f;   // {zero, carry, neg, ovf}
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_operation;
  logic [W-1:0] in1, in2;
  logic [W-1:0] result;
  logic         done;
  logic         zero_flag, carry_flag, neg_flag, ovf_flag;

  int n_pass  = 0;
  int n_total = 0;

  exp_t q[$];
  logic m_z, m_c, m_n, m_v;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_operation(alu_operation), .in1(in1), .in2(in2), .result(result),
    .done(done), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .neg_flag(neg_flag), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: plain integer arithmetic on the opcode rules
  task automatic predict(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua, ub, full, half, sa, sb, s, ss, p, r;
    logic c, v;
    bit hold;
    ua = longint'(a); ub = longint'(b);
    full = longint'(1) << W; half = longint'(1) << (W - 1);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    c = 1'b0; v = 1'b0; hold = 1'b0; r = 0;
    case (op)
      3'd0: r = ub;
      3'd1: begin
        s = ua + ub; r = s % full; c = (s >= full);
        ss = sa + sb; v = (ss >= half) || (ss < -half);
      end
      3'd2: begin
        r = (ua - ub + full) % full; c = (ua < ub);
        ss = sa - sb; v = (ss >= half) || (ss < -half);
      end
      3'd3: r = longint'(a & b);
      3'd4: r = longint'(a | b);
      3'd5: r = full - 1 - ub;
      3'd6: begin r = ua; hold = 1'b1; end
      default: begin
`ifdef ALU_MUL_EN
        p = ua * ub; r = p % full; c = (p >= full); v = c;
`else
        p = 0; r = ua + p; hold = 1'b1;
`endif
      end
    endcase
    if (!hold) begin
      m_z = (r == 0); m_c = c; m_n = (r >= half); m_v = v;
    end
    q.push_back('{r: W'(r), f: {m_z, m_c, m_n, m_v}});
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; alu_operation = op; in1 = a; in2 = b;
  endtask

  task automatic apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    drive(op, a, b);
    predict(op, a, b);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      n_total++;
      $error("FAIL %s: observed completion expected none queued", tag);
      return;
    end
    e = q.pop_front();
    chk({tag, "_done"}, 32'(done), 32'(1));
    chk({tag, "_res"}, 32'(result), 32'(e.r));
    chk({tag, "_flags"}, 32'({zero_flag, carry_flag, neg_flag, ovf_flag}), 32'(e.f));
  endtask

  task automatic single(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    apply(op, a, b);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_out(tag);
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Back-to-back requests, one per cycle, each result checked one cycle later
  task automatic stream(input int n, input int max_op, input string tag);
    for (int i = 0; i < n; i++) begin
      apply(3'($urandom_range(0, max_op)), rnd_opnd(), rnd_opnd());
      @(negedge clk);
      if (i > 0) check_out(tag);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_out(tag);
  endtask

  initial begin
    int low;
    rst = 1'b1; in_valid = 1'b0; alu_operation = '0; in1 = '0; in2 = '0;
    m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_v = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_flags", 32'({zero_flag, carry_flag, neg_flag, ovf_flag}), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;
    @(negedge clk);

    // Seven ops back-to-back on 10, 6
    for (int i = 0; i < 7; i++) begin
      apply(3'(i), W'(10), W'(6));
      @(negedge clk);
      if (i > 0) check_out("b2b");
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_out("b2b");
    @(negedge clk);
    chk("b2b_done_low", 32'(done), 32'(0));

    // Flag boundaries
    single(3'd2, W'(10), W'(10), "sub_zero");
    single(3'd1, W'('hFFFF), W'(1), "add_carry");
    single(3'd2, W'('h8000), W'(1), "sub_ovf");
    single(3'd6, W'('h8000), W'(1), "nop_hold");

`ifdef ALU_MUL_EN
    stream(20, 6, "rnd_stream");

    // 300*300 with 7*9 held during busy
    apply(3'd7, W'(300), W'(300));
    @(negedge clk);
    apply(3'd7, W'(7), W'(9));
    low = 0;
    for (int j = 0; j < int'(W); j++) begin
      chk("mul_ready", 32'(in_ready), (j == int'(W) - 1) ? 32'(1) : 32'(0));
      chk("mul_done_early", 32'(done), 32'(0));
      if (in_ready === 1'b0) low++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_out("mul300");
    chk("mul_low_cycles", 32'(low), 32'(W - 1));
    for (int j = 0; j < int'(W); j++) begin
      if (j > 0) chk("mul_held_busy", 32'(done), 32'(0));
      @(negedge clk);
    end
    check_out("mul63");
    @(negedge clk);

    // Random multiplies
    for (int k = 0; k < 4; k++) begin
      apply(3'd7, rnd_opnd(), W'($urandom));
      @(negedge clk);
      in_valid = 1'b0;
      repeat (W) @(negedge clk);
      check_out("mul_rnd");
    end

    // Reset five cycles into a multiply
    drive(3'd7, W'(1234), W'(567));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
`else
    stream(30, 7, "rnd_stream");

    // Opcode 111 acts as nop
    apply(3'd7, W'(300), W'(300));
    @(negedge clk);
    in_valid = 1'b0;
    chk("op7_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    check_out("op7_nop");
    chk("op7_ready2", 32'(in_ready), 32'(1));

    // Reset with an operation in flight
    drive(3'd1, W'(5), W'(5));
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
`endif
    @(negedge clk);
    rst = 1'b0;
    m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_v = 1'b0;
    chk("abort_result", 32'(result), 32'(0));
    chk("abort_flags", 32'({zero_flag, carry_flag, neg_flag, ovf_flag}), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    @(negedge clk);
    chk("abort_ready", 32'(in_ready), 32'(1));
    chk("abort_no_done", 32'(done), 32'(0));
    single(3'd1, W'(2), W'(3), "post_rst_add");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
